signed_seq_multiplier: RTL and testbench

//  Sequential radix-2 Booth multiplier for two signed DATA_WIDTH operands.

---
 rtl/signed_seq_multiplier_pkg.sv | 26 ++
 rtl/signed_seq_multiplier_if.sv | 22 ++
 rtl/signed_seq_multiplier_booth_step.sv | 31 +++
 rtl/signed_seq_multiplier.sv | 84 ++++++++
 tb/tb_signed_seq_multiplier.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/signed_seq_multiplier_pkg.sv
// Shared encodings for the sequential Booth multiplier: FSM states and the
// per-step Booth recoding decision.
package signed_seq_multiplier_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of {current multiplier bit, previous bit}.
    function automatic booth_op_e booth_op(input logic [1:0] pair);
        case (pair)
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/signed_seq_multiplier_if.sv
// Register-file-facing request/result bundle of the Booth multiplier.
interface signed_seq_multiplier_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  iStart;
    logic [DATA_WIDTH-1:0] iOperandA;
    logic [DATA_WIDTH-1:0] iOperandB;
    logic                  oBusy;
    logic                  oDone;
    logic [DATA_WIDTH-1:0] oParteBaja;
    logic [DATA_WIDTH-1:0] oParteAlta;

    modport master (
        output iStart, iOperandA, iOperandB,
        input  oBusy, oDone, oParteBaja, oParteAlta
    );

    modport slave (
        input  iStart, iOperandA, iOperandB,
        output oBusy, oDone, oParteBaja, oParteAlta
    );
endinterface

// File: rtl/signed_seq_multiplier_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand into the
// high part, then arithmetic shift right of the whole accumulator.
module signed_seq_multiplier_booth_step
    import signed_seq_multiplier_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [2*DATA_WIDTH+1:0] acc_i,
    input  logic [DATA_WIDTH-1:0]   mcand_i,
    output logic [2*DATA_WIDTH+1:0] acc_o
);
    localparam int DW = DATA_WIDTH;

    // Accumulator layout: {high[DW:0], multiplier[DW-1:0], booth_bit}.
    logic [DW:0] hi;
    logic [DW:0] ext;
    logic [DW:0] sum;

    always_comb begin
        hi  = acc_i[2*DW+1:DW+1];
        ext = {mcand_i[DW-1], mcand_i};
        sum = hi;
        case (booth_op(acc_i[1:0]))
            BOOTH_ADD: sum = hi + ext;
            BOOTH_SUB: sum = hi - ext;
            default:   sum = hi;
        endcase
        acc_o = {sum[DW], sum, acc_i[DW:1]};
    end

endmodule

// File: rtl/signed_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one step per cycle, result halves are
// registered on completion and oDone strobes the register-file write path.
module signed_seq_multiplier
    import signed_seq_multiplier_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    signed_seq_multiplier_if.slave  bus
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    mul_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*DW+1:0]    acc_q, acc_d;
    logic [2*DW+1:0]    acc_step;
    logic [DW-1:0]      mcand_q, mcand_d;
    logic [DW-1:0]      lo_q, lo_d;
    logic [DW-1:0]      hi_q, hi_d;

    signed_seq_multiplier_booth_step #(.DATA_WIDTH(DW)) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .acc_o   (acc_step)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        case (state_q)
            MUL_IDLE: begin
                if (bus.iStart) begin
                    mcand_d = bus.iOperandA;
                    acc_d   = {{(DW+1){1'b0}}, bus.iOperandB, 1'b0};
                    cnt_d   = '0;
                    state_d = MUL_RUN;
                end
            end
            MUL_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                // Final step: the product sits just above the Booth bit.
                if (cnt_q == LAST_STEP) begin
                    lo_d    = acc_step[DW:1];
                    hi_d    = acc_step[2*DW:DW+1];
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    assign bus.oBusy      = (state_q == MUL_RUN) || (state_q == MUL_DONE);
    assign bus.oDone      = (state_q == MUL_DONE);
    assign bus.oParteBaja = lo_q;
    assign bus.oParteAlta = hi_q;

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Scoreboard bench: stimulus pushes expected products, a negedge monitor pops
// on every oDone and checks latency and both result halves.
module tb_signed_seq_multiplier;
    localparam int DW = 16;
    localparam int N  = DW;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    signed_seq_multiplier_if #(.DATA_WIDTH(DW)) bus ();

    signed_seq_multiplier #(.DATA_WIDTH(DW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        int            t0;
        string         tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed integer multiply, split into halves.
    function automatic void ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    output logic [DW-1:0] hi, output logic [DW-1:0] lo);
        longint p;
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p[2*DW-1:DW];
        lo = p[DW-1:0];
    endfunction

    // Monitor: result checks on oDone, busy-window length on each busy fall.
    initial begin
        int   busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                busy_run = 0;
            end else begin
                if (bus.oBusy) busy_run++;
                else if (busy_run != 0) begin
                    chk("busy_len", busy_run, N + 1);
                    busy_run = 0;
                end
                if (bus.oDone) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done got oDone=1 required no pending op (cyc %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk({e.tag, "_latency"}, cyc - e.t0, N);
                        chk({e.tag, "_hi"}, bus.oParteAlta, e.hi);
                        chk({e.tag, "_lo"}, bus.oParteBaja, e.lo);
                    end
                end
            end
        end
    end

    task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] ehi, input logic [DW-1:0] elo,
                            input string tag);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge Clock);
        while (bus.oBusy && guard < 100) begin
            @(negedge Clock);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_wait got busy stuck required idle", tag);
        end
        bus.iOperandA = a;
        bus.iOperandB = b;
        bus.iStart    = 1'b1;
        @(posedge Clock);
        #1;
        e.hi = ehi; e.lo = elo; e.t0 = cyc; e.tag = tag;
        sb.push_back(e);
        bus.iStart    = 1'b0;
        bus.iOperandA = DW'($urandom);
        bus.iOperandB = DW'($urandom);
    endtask

    task automatic start_rand(input logic [DW-1:0] a, input logic [DW-1:0] b, input string tag);
        logic [DW-1:0] h, l;
        ref_mul(a, b, h, l);
        start_op(a, b, h, l, tag);
    endtask

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 1000) begin
            @(negedge Clock);
            guard++;
        end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge Clock);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain got %0d pending required 0", tag, sb.size());
            sb.delete();
        end
        repeat (2) @(negedge Clock);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, bus.oBusy, 0);
        chk({tag, "_done"}, bus.oDone, 0);
        chk({tag, "_lo"}, bus.oParteBaja, 0);
        chk({tag, "_hi"}, bus.oParteAlta, 0);
    endtask

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        int c0;
        bus.iStart    = 1'b0;
        bus.iOperandA = '0;
        bus.iOperandB = '0;

        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        chk_reset_outputs("reset");
        Reset = 1'b1;

        start_op(16'd3, 16'd5, 16'h0000, 16'h000F, "d3x5");
        drain("d3x5");
        start_op(16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, "dm3x5");
        drain("dm3x5");
        start_op(16'h8000, 16'h8000, 16'h4000, 16'h0000, "dminxmin");
        drain("dminxmin");
        // Back-to-back: second start issued at the first idle cycle.
        start_op(16'h7FFF, 16'h7FFF, 16'h3FFF, 16'h0001, "dmaxxmax");
        start_op(16'h7FFF, 16'h8000, 16'hC000, 16'h8000, "dmaxxmin");
        drain("b2b");

        // Starts during RUN and DONE must be ignored and not queued.
        start_op(16'd2, 16'd3, 16'h0000, 16'h0006, "d2x3");
        c0 = sb[$].t0;
        wait_cyc(c0 + 4);
        bus.iStart = 1'b1; bus.iOperandA = 16'h1234; bus.iOperandB = 16'h5678;
        @(negedge Clock);
        bus.iStart = 1'b0;
        wait_cyc(c0 + 15);
        bus.iStart = 1'b1; bus.iOperandA = 16'h0F0F; bus.iOperandB = 16'h00FF;
        @(negedge Clock);
        @(negedge Clock);
        bus.iStart = 1'b0;
        drain("d2x3");
        repeat (20) @(negedge Clock);
        chk("no_queued_start_busy", bus.oBusy, 0);

        // Reset mid-operation aborts without a done pulse.
        start_op(16'h1357, 16'h2468, 16'h0000, 16'h0000, "abort");
        c0 = sb[$].t0;
        wait_cyc(c0 + 8);
        Reset = 1'b0;
        sb.delete();
        repeat (2) @(negedge Clock);
        chk_reset_outputs("abort_reset");
        Reset = 1'b1;
        repeat (20) @(negedge Clock);
        chk("abort_no_busy", bus.oBusy, 0);
        start_op(16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF, "d1xm1");
        drain("d1xm1");

        for (int i = 0; i < 40; i++) begin
            start_rand(pick_operand(), pick_operand(), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) == 0) drain("rnd");
            else repeat ($urandom_range(0, 3)) @(negedge Clock);
        end
        drain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
